// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side executor.
// Operands are 32-bit signed; results are 64-bit signed so no ALU result overflows.
package instr_register_pkg;

    localparam int ADDR_W = 5;
    localparam int RES_W  = 64;
    localparam int OP_W   = 32;

    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [OP_W-1:0]  operand_t;
    typedef logic [ADDR_W-1:0]       address_t;
    typedef logic signed [RES_W-1:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE, FETCH, CAPTURE, OUT, FIN
    } exec_state_t;

    function automatic result_t sign_ext(input operand_t op);
        return {{(RES_W-OP_W){op[OP_W-1]}}, op};
    endfunction

endpackage

// File: rtl/instr_exec_alu.sv
// Combinational signed ALU: executes one instruction on sign-extended operands.
// Divide or modulo by zero yields 0 and raises err.
module instr_exec_alu
    import instr_register_pkg::*;
(
    input  opcode_t                 opc,
    input  operand_t                op_a,
    input  operand_t                op_b,
    output logic signed [RES_W-1:0] result,
    output logic                    err
);

    result_t a_ext;
    result_t b_ext;

    assign a_ext = sign_ext(op_a);
    assign b_ext = sign_ext(op_b);

    always_comb begin
        result = '0;
        err    = 1'b0;
        unique case (opc)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV: begin
                if (b_ext == '0) err = 1'b1;
                else             result = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) err = 1'b1;
                else             result = a_ext % b_ext;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_reader.sv
// Read-side consumer of instr_register: walks COUNT locations from start_addr,
// executes each instruction and streams one registered result per beat.
module instr_exec_reader
    import instr_register_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic [ADDR_W:0]         count,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       read_pointer,
    input  instruction_t            instruction_word,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ADDR_W-1:0]       res_addr,
    output opcode_t                 res_opc,
    output logic signed [RES_W-1:0] result,
    output logic                    res_err
);

    exec_state_t        state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               res_valid_q, res_valid_d;
    logic [ADDR_W-1:0]  res_addr_q, res_addr_d;
    opcode_t            res_opc_q, res_opc_d;
    result_t            result_q, result_d;
    logic               res_err_q, res_err_d;

    result_t            alu_result;
    logic               alu_err;

    instr_exec_alu u_alu (
        .opc    (instruction_word.opc),
        .op_a   (instruction_word.op_a),
        .op_b   (instruction_word.op_b),
        .result (alu_result),
        .err    (alu_err)
    );

    // read_pointer is loaded on entry to FETCH so the address is already valid
    // during FETCH; on the final handshake it is left on the last location read.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        rd_ptr_d    = rd_ptr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        res_opc_d   = res_opc_q;
        result_d    = result_q;
        res_err_d   = res_err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d   = start_addr;
                        rd_ptr_d = start_addr;
                        rem_d    = count;
                        busy_d   = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            FETCH: state_d = CAPTURE;
            CAPTURE: begin
                res_addr_d  = addr_q;
                res_opc_d   = instruction_word.opc;
                result_d    = alu_result;
                res_err_d   = alu_err;
                res_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rem_d       = rem_q - 1'b1;
                    addr_d      = addr_q + 1'b1;
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        rd_ptr_d = addr_q + 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            rd_ptr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_opc_q   <= ZERO;
            result_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            rd_ptr_q    <= rd_ptr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            res_opc_q   <= res_opc_d;
            result_q    <= result_d;
            res_err_q   <= res_err_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign read_pointer = rd_ptr_q;
    assign res_valid    = res_valid_q;
    assign res_addr     = res_addr_q;
    assign res_opc      = res_opc_q;
    assign result       = result_q;
    assign res_err      = res_err_q;

endmodule
